// File: rtl/lsm_mem_sequencer_pkg.sv
// Shared definitions for the load/store-multiple memory sequencer:
// state encodings, addressing modes, word size, IR field positions and helpers.
package lsm_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_REQ   = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Mode is {P,U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  localparam int IR_P = 24;
  localparam int IR_U = 23;
  localparam int IR_W = 21;
  localparam int IR_L = 20;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  // Lowest transfer address; transfers always climb upward from here.
  function automatic logic [31:0] start_addr(input mode_t mode, input logic [31:0] base,
                                             input logic [31:0] span);
    logic [31:0] a;
    case (mode)
      MODE_IA: a = base;
      MODE_IB: a = base + WORD_BYTES;
      MODE_DA: a = base - span + WORD_BYTES;
      default: a = base - span;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit encoder over a 16-entry register list.
module lsm_prio_enc (
  input  logic [15:0] list,
  output logic [3:0]  index,
  output logic        valid
);

  always_comb begin
    index = 4'd0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        index = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsm_mem_sequencer.sv
// Memory-side LDM/STM sequencer: one request per listed register, ascending
// addresses, MOC handshake, base-writeback report at the end.
//
// state | meaning
// IDLE  | waiting for START; latches instruction fields and base
// SETUP | popcount, start address and writeback value
// REQ   | MFA high, address/register held until MOC
// NEXT  | MFA low one cycle, step to next register or finish
// FIN   | DONE pulse, WB_EN if W and list was non-empty
module lsm_mem_sequencer
  import lsm_mem_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] IR,
  input  logic [31:0] BASE,
  input  logic        MOC,
  output logic        MFA,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  REG_ADDR,
  output logic        MEM_RW,
  output logic        BUSY,
  output logic        DONE,
  output logic        WB_EN,
  output logic [31:0] WB_VALUE
);

  state_t      state;
  logic [15:0] list_q;
  logic        p_q, u_q, w_q;
  logic [31:0] base_q;
  logic [4:0]  n_cnt;
  logic [31:0] span;
  logic [3:0]  enc_idx;
  logic        enc_valid;

  logic unused_ir;
  assign unused_ir = ^{IR[31:25], IR[22], IR[19:16]};

  assign n_cnt = popcount16(list_q);
  assign span  = {25'b0, n_cnt, 2'b00};

  // The serviced bit is cleared as REQ exits, so NEXT already sees the remainder.
  lsm_prio_enc u_enc (
    .list  (list_q),
    .index (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      list_q   <= '0;
      p_q      <= 1'b0;
      u_q      <= 1'b0;
      w_q      <= 1'b0;
      base_q   <= '0;
      MFA      <= 1'b0;
      MEM_ADDR <= '0;
      REG_ADDR <= '0;
      MEM_RW   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      WB_EN    <= 1'b0;
      WB_VALUE <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            list_q <= IR[15:0];
            p_q    <= IR[IR_P];
            u_q    <= IR[IR_U];
            w_q    <= IR[IR_W];
            MEM_RW <= IR[IR_L];
            base_q <= BASE;
            BUSY   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          WB_VALUE <= u_q ? base_q + span : base_q - span;
          if (n_cnt == 5'd0) begin
            DONE  <= 1'b1;
            WB_EN <= 1'b0;
            state <= S_FIN;
          end else begin
            MFA      <= 1'b1;
            MEM_ADDR <= start_addr(mode_t'({p_q, u_q}), base_q, span);
            REG_ADDR <= enc_idx;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (MOC) begin
            MFA              <= 1'b0;
            list_q[REG_ADDR] <= 1'b0;
            state            <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (enc_valid) begin
            MFA      <= 1'b1;
            MEM_ADDR <= MEM_ADDR + WORD_BYTES;
            REG_ADDR <= enc_idx;
            state    <= S_REQ;
          end else begin
            DONE  <= 1'b1;
            WB_EN <= w_q;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          DONE  <= 1'b0;
          WB_EN <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_mem_sequencer.sv
// Directed bench for lsm_mem_sequencer: drives instruction/base, answers MFA
// with MOC after k cycles, records each transfer and checks against hand values.
module tb_lsm_mem_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, START, MOC;
  logic [31:0] IR, BASE;
  logic        MFA, MEM_RW, BUSY, DONE, WB_EN;
  logic [31:0] MEM_ADDR, WB_VALUE;
  logic [3:0]  REG_ADDR;

  lsm_mem_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .IR       (IR),
    .BASE     (BASE),
    .MOC      (MOC),
    .MFA      (MFA),
    .MEM_ADDR (MEM_ADDR),
    .REG_ADDR (REG_ADDR),
    .MEM_RW   (MEM_RW),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WB_EN    (WB_EN),
    .WB_VALUE (WB_VALUE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  int          n_xfer, done_cyc, max_hold, stab_err, gap_err, busy_err, idle_err;
  bit          rst_hit;
  logic        done_wb_en;
  logic [31:0] done_wb_val;
  logic [31:0] x_addr [16];
  logic [3:0]  x_reg  [16];
  logic        x_rw   [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the first observation after the edge that samples START.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] base, input int k,
                        input int restart_cyc, input bit do_reset);
    int cyc, hold, low_len;
    n_xfer = 0; done_cyc = -1; max_hold = 0; stab_err = 0; gap_err = 0; busy_err = 0;
    rst_hit = 1'b0; done_wb_en = 1'bx; done_wb_val = 'x;
    hold = 0; low_len = 0;
    @(negedge CLK);
    IR = ir; BASE = base; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; IR = 32'h0; BASE = 32'hDEAD_BEEF;
    cyc = 1;
    while (cyc < 200) begin
      if (BUSY !== 1'b1) busy_err++;
      START = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        IR = 32'hE8A0_0001; BASE = 32'h5555_0000;
      end
      if (MFA === 1'b1) begin
        if (hold == 0) begin
          if (n_xfer > 0 && low_len != 1) gap_err++;
          if (n_xfer < 16) begin
            x_addr[n_xfer] = MEM_ADDR;
            x_reg[n_xfer]  = REG_ADDR;
            x_rw[n_xfer]   = MEM_RW;
          end
          n_xfer++;
          if (do_reset && n_xfer == 2) begin
            RESET = 1'b1; MOC = 1'b0; #1;
            rst_hit = 1'b1;
            break;
          end
        end else if (n_xfer <= 16) begin
          if (MEM_ADDR !== x_addr[n_xfer-1] || REG_ADDR !== x_reg[n_xfer-1]) stab_err++;
        end
        MOC = (hold == k);
        hold++;
        if (hold > max_hold) max_hold = hold;
        low_len = 0;
      end else begin
        MOC = 1'b0; hold = 0; low_len++;
      end
      if (DONE === 1'b1) begin
        done_cyc = cyc; done_wb_en = WB_EN; done_wb_val = WB_VALUE;
        break;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    START = 1'b0; MOC = 1'b0;
  endtask

  task automatic after_done(input string tag);
    @(posedge CLK); #1;
    chk({tag, "_done_drop"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_drop"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; MOC = 1'b0; IR = '0; BASE = '0;
    #12;
    chk("rst_mfa", 32'(MFA), 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    chk("rst_reg_addr", 32'(REG_ADDR), 32'd0);
    chk("rst_busy_done", {29'b0, BUSY, DONE, WB_EN}, 32'd0);
    chk("rst_wb_value", WB_VALUE, 32'd0);
    @(negedge CLK); RESET = 1'b0;

    // MOC while idle must not start anything
    MOC = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("idle_moc_mfa", 32'(MFA), 32'd0);
    chk("idle_moc_busy", 32'(BUSY), 32'd0);
    MOC = 1'b0;

    // STMIA base 0x1000 list 0x000B W=1 k=0
    run_op(32'hE8A0_000B, 32'h0000_1000, 0, -1, 1'b0);
    chk("t1_nxfer", n_xfer, 32'd3);
    chk("t1_addr0", x_addr[0], 32'h0000_1000);
    chk("t1_addr1", x_addr[1], 32'h0000_1004);
    chk("t1_addr2", x_addr[2], 32'h0000_1008);
    chk("t1_regs", {20'b0, x_reg[0], x_reg[1], x_reg[2]}, 32'h0000_0013);
    chk("t1_rw", 32'(x_rw[0]), 32'd0);
    chk("t1_done_cyc", done_cyc, 32'd8);
    chk("t1_wb_en", 32'(done_wb_en), 32'd1);
    chk("t1_wb_val", done_wb_val, 32'h0000_100C);
    chk("t1_gap", gap_err, 32'd0);
    chk("t1_busy", busy_err, 32'd0);
    after_done("t1");

    // LDMDB base 0x2000 list 0x8001 W=1 k=3
    run_op(32'hE930_8001, 32'h0000_2000, 3, -1, 1'b0);
    chk("t2_nxfer", n_xfer, 32'd2);
    chk("t2_addr0", x_addr[0], 32'h0000_1FF8);
    chk("t2_reg0", 32'(x_reg[0]), 32'd0);
    chk("t2_addr1", x_addr[1], 32'h0000_1FFC);
    chk("t2_reg1", 32'(x_reg[1]), 32'd15);
    chk("t2_rw", 32'(x_rw[1]), 32'd1);
    chk("t2_hold", max_hold, 32'd4);
    chk("t2_stable", stab_err, 32'd0);
    chk("t2_gap", gap_err, 32'd0);
    chk("t2_done_cyc", done_cyc, 32'd12);
    chk("t2_wb_en", 32'(done_wb_en), 32'd1);
    chk("t2_wb_val", done_wb_val, 32'h0000_1FF8);
    after_done("t2");

    // LDMIB base 0xFFFFFFFC list 0x0003 W=0 k=1, address wraps
    run_op(32'hE990_0003, 32'hFFFF_FFFC, 1, -1, 1'b0);
    chk("t3_nxfer", n_xfer, 32'd2);
    chk("t3_addr0", x_addr[0], 32'h0000_0000);
    chk("t3_addr1", x_addr[1], 32'h0000_0004);
    chk("t3_regs", {24'b0, x_reg[0], x_reg[1]}, 32'h0000_0001);
    chk("t3_hold", max_hold, 32'd2);
    chk("t3_done_cyc", done_cyc, 32'd8);
    chk("t3_wb_en", 32'(done_wb_en), 32'd0);
    after_done("t3");

    // Empty list, W=1
    run_op(32'hE8A0_0000, 32'h0000_4000, 0, -1, 1'b0);
    chk("t4_nxfer", n_xfer, 32'd0);
    chk("t4_done_cyc", done_cyc, 32'd2);
    chk("t4_wb_en", 32'(done_wb_en), 32'd0);
    chk("t4_busy", busy_err, 32'd0);
    after_done("t4");

    // STMDA base 0x100 full list W=1, START re-pulsed mid-run
    run_op(32'hE820_FFFF, 32'h0000_0100, 0, 5, 1'b0);
    chk("t5_nxfer", n_xfer, 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_addr%0d", i), x_addr[i], 32'h0000_00C4 + 32'(4 * i));
      chk($sformatf("t5_reg%0d", i), 32'(x_reg[i]), 32'(i));
    end
    chk("t5_done_cyc", done_cyc, 32'd34);
    chk("t5_wb_en", 32'(done_wb_en), 32'd1);
    chk("t5_wb_val", done_wb_val, 32'h0000_00C0);
    chk("t5_gap", gap_err, 32'd0);
    after_done("t5");

    // LDMIA base 0x3000 list 0x0007, reset during second request
    run_op(32'hE890_0007, 32'h0000_3000, 2, -1, 1'b1);
    chk("t6_rst_hit", 32'(rst_hit), 32'd1);
    chk("t6_addr1_before", x_addr[1], 32'h0000_3004);
    chk("t6_rst_mfa", 32'(MFA), 32'd0);
    chk("t6_rst_mem_addr", MEM_ADDR, 32'd0);
    chk("t6_rst_reg_addr", 32'(REG_ADDR), 32'd0);
    chk("t6_rst_flags", {28'b0, MEM_RW, BUSY, DONE, WB_EN}, 32'd0);
    chk("t6_rst_wb_value", WB_VALUE, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || MFA !== 1'b0 || BUSY !== 1'b0) idle_err++;
    end
    chk("t6_quiet_after_rst", idle_err, 32'd0);

    run_op(32'hE8A0_000B, 32'h0000_1000, 0, -1, 1'b0);
    chk("t7_nxfer", n_xfer, 32'd3);
    chk("t7_addr2", x_addr[2], 32'h0000_1008);
    chk("t7_reg2", 32'(x_reg[2]), 32'd3);
    chk("t7_done_cyc", done_cyc, 32'd8);
    chk("t7_wb_val", done_wb_val, 32'h0000_100C);
    after_done("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
